ps2_key_encoder: RTL and testbench
==================================

PS2_KEY_ENCODER -- requirements
Module: ps2_key_encoder

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 12000, meaning clk_sys cycles without a PS/2 clock falling edge before an open frame is abandoned (1 ms at 12 MHz).
REQ-002 The module SHALL have port clk_sys  input  1  system clock; the only clock.
REQ-003 The module SHALL have port reset_n  input  1  reset, synchronous to clk_sys, active-low.
REQ-004 The module SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk_sys.
REQ-005 The module SHALL have port ps2_data  input  1  raw PS/2 data line, asynchronous to clk_sys.
REQ-006 The module SHALL have port ps2_key  output  11  key event word: [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
REQ-007 The module SHALL have port frame_err  output  1  one-cycle pulse per discarded frame.

Function
REQ-008 ps2_clk and ps2_data SHALL each pass through a 2-flop synchroniser; a falling edge is synced-clock 1 -> 0 between consecutive cycles.
REQ-009 The frame FSM SHALL have states IDLE, DATA, PARITY, STOP and SHALL sample synced data only on a detected falling edge.
REQ-010 IDLE: edge with data=0 -> DATA with bit count 0; edge with data=1 -> stay IDLE, no error.
REQ-011 DATA: shift in 8 bits LSB first; after the 8th bit -> PARITY.
REQ-012 PARITY: capture the parity bit -> STOP; the 8 data bits plus parity SHALL have odd weight.
REQ-013 STOP: on the edge, data=1 with good parity -> byte valid; otherwise -> frame_err; either way -> IDLE.
REQ-014 Outside IDLE, a cycle counter SHALL clear on every edge; after TIMEOUT consecutive edge-free cycles the FSM SHALL go to IDLE, pulse frame_err and discard the partial byte.
REQ-015 If the timeout and an edge occur in the same cycle, the edge SHALL win.
REQ-016 A valid byte 0xE0 SHALL set the ext flag; 0xF0 SHALL set the brk flag; neither SHALL change ps2_key.
REQ-017 Prefixes SHALL be order-insensitive and cumulative: E0 F0 and F0 E0 both set ext and brk.
REQ-018 Any other valid byte B SHALL set ps2_key to {~ps2_key[10], ~brk, ext, B} and clear ext and brk.
REQ-019 Update latency: ps2_key SHALL change exactly 2 clk_sys cycles after the cycle in which the stop-bit edge is detected.
REQ-020 ps2_key SHALL otherwise hold its value; ps2_key[10] flips exactly once per emitted event.
REQ-021 frame_err (parity, stop or timeout) SHALL clear ext and brk and SHALL leave ps2_key unchanged.
REQ-022 The sequences 0xAA, 0xFA and 0xFE SHALL be emitted as ordinary codes, with no special handling.

Reset
REQ-023 While reset_n=0 at a clk_sys edge: FSM=IDLE, ps2_key=11'h000, frame_err=0, ext=brk=0, counters=0, synchroniser flops=1.
REQ-024 Reset mid-frame SHALL abandon the frame with no event and no frame_err.

Configuration
REQ-025 With macro PS2_PAUSE_FILTER_EN defined, a valid 0xE1 in IDLE prefix state SHALL cause the next 7 valid bytes to be swallowed, with no ps2_key change.
REQ-026 The skip count SHALL be cleared by frame_err or reset.
REQ-027 Without PS2_PAUSE_FILTER_EN, 0xE1 SHALL be treated as an ordinary code per REQ-018.

Verification
REQ-028 After reset, send 0x29 -> ps2_key=11'h629 exactly 2 cycles after the stop edge; frame_err stays 0.
REQ-029 Then send F0 29 -> ps2_key=11'h029, with no change after the F0 byte.
REQ-030 Send E0 75 -> 11'h775; then F0 E0 75 -> 11'h175.
REQ-031 Send E0, then 0x16 with a wrong parity bit -> one frame_err pulse, ps2_key unchanged; then send 0x16 -> 11'h616 (ext cleared, toggle flipped relative to prior value).
REQ-032 With TIMEOUT=100, stop clocking after 4 data bits -> frame_err pulses 100 cycles after the last edge; then send 0x1E -> event with code 0x1E.
REQ-033 Send E1 14 77 E1 F0 14 F0 77 -> with PS2_PAUSE_FILTER_EN: no ps2_key change; without it: the events are E1 make, 14 make, 77 make, E1 make, 14 break, 77 break, in that order.

Source files
------------

// File: rtl/ps2_key_encoder.sv
// ---------------------------------------------------------------------------
// ps2_key_encoder
//
// Receives PS/2 keyboard frames (start, 8 data bits LSB first, odd parity,
// stop), folds the E0/F0 prefix bytes into flags and publishes one 11-bit key
// event word per ordinary scancode.
//
// Ports
//   clk_sys   : system clock, the only clock domain
//   reset_n   : synchronous active-low reset
//   ps2_clk   : raw PS/2 clock line (asynchronous)
//   ps2_data  : raw PS/2 data line (asynchronous)
//   ps2_key   : [10] toggle, [9] pressed, [8] extended, [7:0] scancode
//   frame_err : one-cycle pulse for each discarded frame (parity, stop, timeout)
//
// Parameter
//   TIMEOUT   : clk_sys cycles without a PS/2 clock falling edge before an
//               open frame is abandoned
//
// Optional feature
//   PS2_PAUSE_FILTER_EN : when defined, a 0xE1 received with no prefix pending
//                         swallows the following 7 valid bytes (Pause key).
// ---------------------------------------------------------------------------
module ps2_key_encoder #(
    parameter int TIMEOUT = 12000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Synchroniser and edge detector.  Flops reset high so that a released
    // (idle-high) bus never looks like a falling edge coming out of reset.
    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;
    logic       fall;
    logic       bit_in;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[1];
    assign bit_in = data_sync[1];

    // Frame FSM registers
    state_t          state, state_next;
    logic [2:0]      bit_cnt, bit_cnt_next;
    logic [7:0]      shift, shift_next;
    logic            par_bit, par_next;
    logic [CW-1:0]   timer, timer_next;
    logic            valid_next;
    logic            err_next;
    logic            byte_valid;
    logic [7:0]      byte_data;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            par_bit    <= 1'b0;
            timer      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            shift      <= shift_next;
            par_bit    <= par_next;
            timer      <= timer_next;
            byte_valid <= valid_next;
            frame_err  <= err_next;
            if (valid_next) begin
                byte_data <= shift;
            end
        end
    end

    // Next-state logic.  Every bit is taken only on a detected falling edge.
    // The inactivity timer runs in every state but IDLE; because the timeout
    // branch is only reachable when no edge is present, an edge arriving in
    // the expiry cycle is processed normally.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        par_next     = par_bit;
        timer_next   = timer;
        valid_next   = 1'b0;
        err_next     = 1'b0;

        case (state)
            IDLE: begin
                timer_next = '0;
                if (fall && !bit_in) begin
                    state_next   = DATA;
                    bit_cnt_next = 3'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_next   = {bit_in, shift[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_next   = bit_in;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_next = IDLE;
                    if (bit_in && (^{shift, par_bit})) begin
                        valid_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state != IDLE) begin
            if (fall) begin
                timer_next = '0;
            end else if (timer == CW'(TIMEOUT - 1)) begin
                state_next = IDLE;
                err_next   = 1'b1;
                timer_next = '0;
            end else begin
                timer_next = timer + CW'(1);
            end
        end
    end

    // Prefix flags gathered ahead of the scancode they qualify
    logic ext;
    logic brk;
    logic swallow;

`ifdef PS2_PAUSE_FILTER_EN
    // Pause key filter: an unprefixed E1 starts an 8-byte sequence; the E1
    // and the 7 bytes after it produce no event.
    logic [2:0] skip_cnt;
    logic       pause_start;

    assign pause_start = (byte_data == 8'hE1) && !ext && !brk && (skip_cnt == 3'd0);
    assign swallow     = byte_valid && ((skip_cnt != 3'd0) || pause_start);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            skip_cnt <= 3'd0;
        end else if (frame_err) begin
            skip_cnt <= 3'd0;
        end else if (byte_valid) begin
            if (skip_cnt != 3'd0) begin
                skip_cnt <= skip_cnt - 3'd1;
            end else if (pause_start) begin
                skip_cnt <= 3'd7;
            end
        end
    end
`else
    assign swallow = 1'b0;
`endif

    // Event stage: one cycle behind the frame FSM, which gives the two-cycle
    // latency from the stop-bit edge to the ps2_key update.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            ps2_key <= 11'h000;
            ext     <= 1'b0;
            brk     <= 1'b0;
        end else if (frame_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (byte_valid && !swallow) begin
            if (byte_data == 8'hE0) begin
                ext <= 1'b1;
            end else if (byte_data == 8'hF0) begin
                brk <= 1'b1;
            end else begin
                ps2_key <= {~ps2_key[10], ~brk, ext, byte_data};
                ext     <= 1'b0;
                brk     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_encoder
//
// Directed bench for ps2_key_encoder built with TIMEOUT=100.  PS/2 frames are
// bit-banged aligned to clk_sys falling edges (16 clk_sys per PS/2 bit).
// ---------------------------------------------------------------------------
module tb_ps2_key_encoder;

    localparam int TO = 100;

    logic        clk_sys  = 1'b0;
    logic        reset_n  = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    int checks     = 0;
    int errors     = 0;
    int err_pulses = 0;

    logic [10:0] key_pre;
    logic [10:0] key_post;
    logic [10:0] last_key;

    ps2_key_encoder #(.TIMEOUT(TO)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    // Running count of frame_err cycles
    always @(posedge clk_sys) begin
        if (frame_err === 1'b1) begin
            err_pulses <= err_pulses + 1;
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Present a data bit, hold it for 'pre' cycles, then drop the PS/2 clock
    task automatic drive_bit(input logic b, input int pre);
        ps2_data = b;
        wait_neg(pre);
        ps2_clk = 1'b0;
    endtask

    task automatic release_clk();
        wait_neg(8);
        ps2_clk = 1'b1;
        wait_neg(4);
    endtask

    // Full frame.  stretch_bit selects a bit whose falling edge arrives exactly
    // TO cycles after the previous one (the expiry cycle).  key_pre is sampled
    // 3 clk_sys edges after the stop-bit clock drop, key_post after 4.
    task automatic send_frame(input logic [7:0] b, input logic bad_par,
                              input logic bad_stop, input int stretch_bit);
        logic [10:0] bits;
        int pre;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        wait_neg(1);
        for (int i = 0; i < 11; i++) begin
            pre = (i == stretch_bit) ? (TO - 12) : 4;
            drive_bit(bits[i], pre);
            if (i < 10) begin
                release_clk();
            end
        end
        repeat (3) @(posedge clk_sys);
        #1 key_pre = ps2_key;
        @(posedge clk_sys);
        #1 key_post = ps2_key;
        @(negedge clk_sys);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_neg(16);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1;
        checks++;
        if (ps2_key !== 11'h000) begin
            errors++;
            $display("[TB] FAIL reset_key: got %h expected %h", ps2_key, 11'h000);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_err: got %b expected 0", frame_err);
        end
        @(negedge clk_sys);
        reset_n = 1'b1;
        wait_neg(4);
        last_key = 11'h000;
    endtask

    task automatic test_make_break();
        logic [7:0]  codes [8];
        logic [10:0] expk  [8];
        int e0;
        codes = '{8'h29, 8'hF0, 8'h29, 8'hE0, 8'h75, 8'hF0, 8'hE0, 8'h75};
        expk  = '{11'h629, 11'h629, 11'h029, 11'h029, 11'h775, 11'h775, 11'h775, 11'h175};
        e0 = err_pulses;
        for (int i = 0; i < 8; i++) begin
            send_frame(codes[i], 1'b0, 1'b0, -1);
            checks++;
            if (key_pre !== last_key) begin
                errors++;
                $display("[TB] FAIL mb_latency[%0d]: got %h expected %h", i, key_pre, last_key);
            end
            checks++;
            if (key_post !== expk[i]) begin
                errors++;
                $display("[TB] FAIL mb_key[%0d]: got %h expected %h", i, key_post, expk[i]);
            end
            last_key = expk[i];
        end
        checks++;
        if (err_pulses !== e0) begin
            errors++;
            $display("[TB] FAIL mb_no_err: got %0d pulses expected 0", err_pulses - e0);
        end
    endtask

    task automatic test_frame_errors();
        int e0;
        // E0 then bad parity: error, ext discarded
        send_frame(8'hE0, 1'b0, 1'b0, -1);
        e0 = err_pulses;
        send_frame(8'h16, 1'b1, 1'b0, -1);
        checks++;
        if (err_pulses !== e0 + 1) begin
            errors++;
            $display("[TB] FAIL parity_err: got %0d pulses expected 1", err_pulses - e0);
        end
        checks++;
        if (key_post !== 11'h175) begin
            errors++;
            $display("[TB] FAIL parity_hold: got %h expected %h", key_post, 11'h175);
        end
        send_frame(8'h16, 1'b0, 1'b0, -1);
        checks++;
        if (key_post !== 11'h616) begin
            errors++;
            $display("[TB] FAIL parity_recover: got %h expected %h", key_post, 11'h616);
        end
        // E0 F0 then bad stop bit: error, both flags discarded
        send_frame(8'hE0, 1'b0, 1'b0, -1);
        send_frame(8'hF0, 1'b0, 1'b0, -1);
        e0 = err_pulses;
        send_frame(8'h16, 1'b0, 1'b1, -1);
        checks++;
        if (err_pulses !== e0 + 1) begin
            errors++;
            $display("[TB] FAIL stop_err: got %0d pulses expected 1", err_pulses - e0);
        end
        checks++;
        if (key_post !== 11'h616) begin
            errors++;
            $display("[TB] FAIL stop_hold: got %h expected %h", key_post, 11'h616);
        end
        send_frame(8'h16, 1'b0, 1'b0, -1);
        checks++;
        if (key_post !== 11'h216) begin
            errors++;
            $display("[TB] FAIL stop_recover: got %h expected %h", key_post, 11'h216);
        end
        last_key = 11'h216;
    endtask

    task automatic test_timeout();
        int hits;
        int first;
        hits  = 0;
        first = -1;
        send_frame(8'hE0, 1'b0, 1'b0, -1);
        // Start bit plus 4 data bits, then the keyboard goes silent
        wait_neg(1);
        drive_bit(1'b0, 4);
        for (int i = 0; i < 4; i++) begin
            release_clk();
            drive_bit(1'b1, 4);
        end
        for (int i = 1; i <= TO + 10; i++) begin
            @(posedge clk_sys);
            #1;
            if (frame_err === 1'b1) begin
                hits++;
                if (first < 0) begin
                    first = i;
                end
            end
            if (i == 8) begin
                ps2_clk = 1'b1;
            end
        end
        checks++;
        if (hits !== 1) begin
            errors++;
            $display("[TB] FAIL timeout_pulses: got %0d expected 1", hits);
        end
        checks++;
        if (first !== TO + 3) begin
            errors++;
            $display("[TB] FAIL timeout_time: got %0d expected %0d", first, TO + 3);
        end
        checks++;
        if (ps2_key !== 11'h216) begin
            errors++;
            $display("[TB] FAIL timeout_hold: got %h expected %h", ps2_key, 11'h216);
        end
        wait_neg(8);
        send_frame(8'h1E, 1'b0, 1'b0, -1);
        checks++;
        if (key_post !== 11'h61E) begin
            errors++;
            $display("[TB] FAIL timeout_recover: got %h expected %h", key_post, 11'h61E);
        end
        last_key = 11'h61E;
    endtask

    task automatic test_edge_wins();
        int e0;
        e0 = err_pulses;
        send_frame(8'h1C, 1'b0, 1'b0, 5);
        checks++;
        if (err_pulses !== e0) begin
            errors++;
            $display("[TB] FAIL edge_wins_err: got %0d pulses expected 0", err_pulses - e0);
        end
        checks++;
        if (key_post !== 11'h21C) begin
            errors++;
            $display("[TB] FAIL edge_wins_key: got %h expected %h", key_post, 11'h21C);
        end
        last_key = 11'h21C;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  codes [3];
        logic [10:0] expk  [3];
        codes = '{8'hAA, 8'hFA, 8'hFE};
        expk  = '{11'h6AA, 11'h2FA, 11'h6FE};
        for (int i = 0; i < 3; i++) begin
            send_frame(codes[i], 1'b0, 1'b0, -1);
            checks++;
            if (key_post !== expk[i]) begin
                errors++;
                $display("[TB] FAIL b2b_key[%0d]: got %h expected %h", i, key_post, expk[i]);
            end
        end
        last_key = 11'h6FE;
    endtask

    task automatic test_pause();
        logic [7:0]  codes [9];
        logic [10:0] expk  [9];
        codes = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29};
`ifdef PS2_PAUSE_FILTER_EN
        expk = '{11'h6FE, 11'h6FE, 11'h6FE, 11'h6FE, 11'h6FE, 11'h6FE, 11'h6FE, 11'h6FE, 11'h229};
`else
        expk = '{11'h2E1, 11'h614, 11'h277, 11'h6E1, 11'h6E1, 11'h014, 11'h014, 11'h477, 11'h229};
`endif
        for (int i = 0; i < 9; i++) begin
            send_frame(codes[i], 1'b0, 1'b0, -1);
            checks++;
            if (key_post !== expk[i]) begin
                errors++;
                $display("[TB] FAIL pause_key[%0d]: got %h expected %h", i, key_post, expk[i]);
            end
        end
        last_key = 11'h229;
    endtask

    task automatic test_reset_mid_frame();
        int e0;
        e0 = err_pulses;
        wait_neg(1);
        drive_bit(1'b0, 4);
        for (int i = 0; i < 3; i++) begin
            release_clk();
            drive_bit(1'b1, 4);
        end
        wait_neg(4);
        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        checks++;
        if (ps2_key !== 11'h000) begin
            errors++;
            $display("[TB] FAIL midreset_key: got %h expected %h", ps2_key, 11'h000);
        end
        @(negedge clk_sys);
        reset_n = 1'b1;
        wait_neg(TO + 50);
        checks++;
        if (err_pulses !== e0) begin
            errors++;
            $display("[TB] FAIL midreset_err: got %0d pulses expected 0", err_pulses - e0);
        end
        send_frame(8'h29, 1'b0, 1'b0, -1);
        checks++;
        if (key_pre !== 11'h000) begin
            errors++;
            $display("[TB] FAIL midreset_latency: got %h expected %h", key_pre, 11'h000);
        end
        checks++;
        if (key_post !== 11'h629) begin
            errors++;
            $display("[TB] FAIL midreset_recover: got %h expected %h", key_post, 11'h629);
        end
        last_key = 11'h629;
    endtask

    initial begin
        $display("[TB] ps2_key_encoder bench start");
        test_reset();
        test_make_break();
        test_frame_errors();
        test_timeout();
        test_edge_wins();
        test_back_to_back();
        test_pause();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
